// File: rtl/jogo_pkg.sv
// ---------------------------------------------------------------------------
// jogo_pkg
// Shared constants and helpers for the jogo front end (detector_jogada) and
// circuito_jogo, which reuses the same db_estado encoding.
//   NUM_BOTOES      : number of board buttons (fixed by board geometry)
//   JOGADA_W        : width of the encoded button index
//   OCIOSO..ESPERA_SOLTAR : FSM state codes shown on the hex display
//   eh_onehot()     : true when exactly one bit of a button vector is set
//   codifica_indice(): position of the set bit of a one-hot button vector
// ---------------------------------------------------------------------------
package jogo_pkg;

  localparam int NUM_BOTOES = 9;
  localparam int JOGADA_W   = 4;

  typedef logic [3:0] estado_t;

  localparam estado_t OCIOSO        = 4'd0;
  localparam estado_t ESTAVEL       = 4'd1;
  localparam estado_t EMITE         = 4'd2;
  localparam estado_t ESPERA_SOLTAR = 4'd3;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic eh_onehot(input logic [NUM_BOTOES-1:0] v);
    logic [NUM_BOTOES-1:0] um;
    um    = '0;
    um[0] = 1'b1;
    return (v != '0) && ((v & (v - um)) == '0);
  endfunction

  // OR of the indices of all set bits; exact for a one-hot input.
  function automatic logic [JOGADA_W-1:0] codifica_indice(input logic [NUM_BOTOES-1:0] v);
    logic [JOGADA_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_BOTOES; i++) begin
      idx = idx | (v[i] ? JOGADA_W'(i) : {JOGADA_W{1'b0}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/detector_jogada_if.sv
// ---------------------------------------------------------------------------
// detector_jogada_if
// Button/play bus between the board-facing producer and detector_jogada.
//   habilita      : presses may be accepted (from the jogo FSM)
//   botoes        : raw button levels, active-high
//   jogada_valida : one-cycle pulse per accepted press
//   jogada        : index of the accepted button, held
//   jogada_onehot : one-hot image of jogada, held
//   erro_jogada   : one-cycle pulse when several buttons were stable
//   db_estado     : detector FSM state code
// Modports: master drives habilita/botoes, slave (the detector) drives the rest.
// ---------------------------------------------------------------------------
interface detector_jogada_if;
  import jogo_pkg::*;

  logic                  habilita;
  logic [NUM_BOTOES-1:0] botoes;
  logic                  jogada_valida;
  logic [JOGADA_W-1:0]   jogada;
  logic [NUM_BOTOES-1:0] jogada_onehot;
  logic                  erro_jogada;
  logic [3:0]            db_estado;

  modport master (
    output habilita, botoes,
    input  jogada_valida, jogada, jogada_onehot, erro_jogada, db_estado
  );

  modport slave (
    input  habilita, botoes,
    output jogada_valida, jogada, jogada_onehot, erro_jogada, db_estado
  );

endinterface

// File: rtl/sincronizador_2ff.sv
// ---------------------------------------------------------------------------
// sincronizador_2ff
// Two-flop synchroniser for asynchronous level inputs; q is d delayed by two
// clock edges.
//   clock : sampling clock
//   reset : asynchronous, active-high; clears both stages to 0
//   d     : asynchronous input vector (WIDTH bits)
//   q     : synchronised output vector
// ---------------------------------------------------------------------------
module sincronizador_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sinc_r;

  // Two-stage capture chain; the first stage may go metastable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_r <= '0;
      sinc_r <= '0;
    end else begin
      meta_r <= d;
      sinc_r <= meta_r;
    end
  end

  assign q = sinc_r;

endmodule

// File: rtl/detector_jogada.sv
// ---------------------------------------------------------------------------
// detector_jogada
// Front end of circuito_jogo: synchronises the 9 board buttons, optionally
// debounces them, rejects multi-button presses and waits for full release,
// issuing one jogada_valida pulse (with index and one-hot image) per press.
//   clock : 50 MHz system clock
//   reset : asynchronous, active-high; clears all state
//   io    : detector_jogada_if.slave (habilita, botoes in; jogada_valida,
//           jogada, jogada_onehot, erro_jogada, db_estado out)
// Parameter DEB_CICLOS (2..255): stable synchronised cycles needed to accept.
// Build option: define DETECTOR_DEBOUNCE_EN to build the ESTAVEL debounce
// state and its counter; without it a press is accepted as soon as the
// synchronised value is non-zero and DEB_CICLOS has no effect.
// ---------------------------------------------------------------------------
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int DEB_CICLOS = 2
) (
  input logic              clock,
  input logic              reset,
  detector_jogada_if.slave io
);

  logic [NUM_BOTOES-1:0] s_s;
  estado_t               estado_r;
  estado_t               estado_nxt_s;
  logic [NUM_BOTOES-1:0] amostra_r;
  logic [NUM_BOTOES-1:0] amostra_nxt_s;
  logic                  entra_emite_s;
  logic                  amostra_onehot_s;
  logic                  jogada_valida_r;
  logic                  erro_jogada_r;
  logic [JOGADA_W-1:0]   jogada_r;
  logic [NUM_BOTOES-1:0] jogada_onehot_r;

`ifdef DETECTOR_DEBOUNCE_EN
  // Terminal count: cnt starts at 1 on capture, so DEB_CICLOS-1 means
  // DEB_CICLOS consecutive matching samples have been seen.
  localparam logic [7:0] CNT_FIM = 8'(DEB_CICLOS - 1);
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
`endif

  // DEB_CICLOS outside 2..255 does not fit the 8-bit counter; nothing is
  // built here, the block only keeps the parameter referenced in every build.
  if ((DEB_CICLOS < 2) || (DEB_CICLOS > 255)) begin : g_deb_ciclos_fora_faixa
  end

  sincronizador_2ff #(
    .WIDTH (NUM_BOTOES)
  ) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (io.botoes),
    .q     (s_s)
  );

  // Next-state, sample capture and debounce counter.
  always_comb begin
    estado_nxt_s  = estado_r;
    amostra_nxt_s = amostra_r;
`ifdef DETECTOR_DEBOUNCE_EN
    cnt_nxt_s     = cnt_r;
`endif
    case (estado_r)
      OCIOSO: begin
        if (s_s != '0) begin
          if (io.habilita) begin
            amostra_nxt_s = s_s;
`ifdef DETECTOR_DEBOUNCE_EN
            cnt_nxt_s     = 8'd1;
            estado_nxt_s  = ESTAVEL;
`else
            estado_nxt_s  = EMITE;
`endif
          end else begin
            // Press started while disabled: must be released before counting.
            estado_nxt_s = ESPERA_SOLTAR;
          end
        end else begin
          estado_nxt_s = OCIOSO;
        end
      end
`ifdef DETECTOR_DEBOUNCE_EN
      ESTAVEL: begin
        if (!io.habilita) begin
          estado_nxt_s = ESPERA_SOLTAR;
        end else if (s_s != amostra_r) begin
          estado_nxt_s = OCIOSO;
        end else if (cnt_r == CNT_FIM) begin
          estado_nxt_s = EMITE;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
`endif
      EMITE: begin
        estado_nxt_s = ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        if (s_s == '0) begin
          estado_nxt_s = OCIOSO;
        end else begin
          estado_nxt_s = ESPERA_SOLTAR;
        end
      end
      default: begin
        estado_nxt_s = OCIOSO;
      end
    endcase
  end

  // The pulses are registered on entry to EMITE, so they are high exactly
  // while estado_r == EMITE and come straight from flops.
  assign entra_emite_s    = (estado_nxt_s == EMITE);
  assign amostra_onehot_s = eh_onehot(amostra_nxt_s);

  // State, sample and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_r  <= OCIOSO;
      amostra_r <= '0;
`ifdef DETECTOR_DEBOUNCE_EN
      cnt_r     <= 8'd0;
`endif
    end else begin
      estado_r  <= estado_nxt_s;
      amostra_r <= amostra_nxt_s;
`ifdef DETECTOR_DEBOUNCE_EN
      cnt_r     <= cnt_nxt_s;
`endif
    end
  end

  // Output registers: pulses for one cycle, jogada held until next accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jogada_valida_r <= 1'b0;
      erro_jogada_r   <= 1'b0;
      jogada_r        <= '0;
      jogada_onehot_r <= '0;
    end else begin
      jogada_valida_r <= entra_emite_s && amostra_onehot_s;
      erro_jogada_r   <= entra_emite_s && !amostra_onehot_s;
      if (entra_emite_s && amostra_onehot_s) begin
        jogada_r        <= codifica_indice(amostra_nxt_s);
        jogada_onehot_r <= amostra_nxt_s;
      end
    end
  end

  assign io.jogada_valida = jogada_valida_r;
  assign io.erro_jogada   = erro_jogada_r;
  assign io.jogada        = jogada_r;
  assign io.jogada_onehot = jogada_onehot_r;
  assign io.db_estado     = estado_r;

endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
- Front-end stage directly upstream of circuito_jogo.
- Conditions the 9 raw board buttons: 2-FF synchroniser, optional debounce, multi-press rejection, release wait.
- Emits exactly one single-cycle jogada_valida pulse per accepted press, with the button index (0..8) and its one-hot image.
- circuito_jogo consumes these in place of the raw botoes vector in both the macro and micro play phases.

Parameters:
- NUM_BOTOES, 9, button count; fixed by board geometry.
- DEB_CICLOS, 2, consecutive stable synchronised cycles required before acceptance; legal range 2..255.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high; clears all state.
- habilita  in  1  high = presses may be accepted (driven by the jogo FSM in its wait-for-move states).
- botoes  in  9  raw button levels, active-high; bit i = button i.
- jogada_valida  out  1  one-cycle pulse: one accepted press.
- jogada  out  4  index 0..8 of the accepted button; held until the next accept.
- jogada_onehot  out  9  one-hot of jogada; held likewise.
- erro_jogada  out  1  one-cycle pulse: more than one button stable at decision time.
- db_estado  out  4  current FSM state code, for hex display.

Behaviour:
- Reset values:
  - all outputs 0; jogada=4'd0, jogada_onehot=9'b0.
  - synchroniser flops = 0; FSM = OCIOSO; counter = 0.
- Synchroniser: s = botoes delayed by 2 clock edges. All FSM decisions use s only.
- FSM states, with db_estado codes:
  - OCIOSO (0):
    - habilita=1 and s!=0: amostra<=s, cnt<=1, go to ESTAVEL.
    - habilita=0 and s!=0: go to ESPERA_SOLTAR.
    - otherwise stay.
  - ESTAVEL (1):
    - habilita=0: go to ESPERA_SOLTAR.
    - s!=amostra: go to OCIOSO (glitch or change; no output).
    - cnt==DEB_CICLOS-1: go to EMITE.
    - otherwise cnt<=cnt+1.
  - EMITE (2), exactly 1 cycle, then go to ESPERA_SOLTAR:
    - amostra one-hot: jogada_valida=1; jogada and jogada_onehot registered on entry to EMITE.
    - amostra not one-hot: erro_jogada=1; jogada and jogada_onehot unchanged.
  - ESPERA_SOLTAR (3): stay while s!=0; go to OCIOSO when s==0. No new press is accepted until full release.
- Outputs: jogada_valida and erro_jogada are decoded from state == EMITE; the registered state makes them glitch-free.
- Latency: botoes rising before clock edge k with DEB_CICLOS=2 gives jogada_valida high in the cycle after edge k+3. Generally the pulse follows edge k+1+DEB_CICLOS.
- Minimum accepted press: DEB_CICLOS clock cycles. A 2-cycle press is accepted at the default.
- Boundary conditions:
  - Held button: exactly one pulse, however long it is held.
  - habilita rising while a button is already held: ignored until release.
  - Second button added during ESTAVEL: s!=amostra, restart from OCIOSO.
  - Simultaneous press of two buttons: erro_jogada, no jogada_valida.
  - habilita falling during EMITE: the pulse still issues.
  - Reset asserted mid-operation: immediate return to reset values, independent of clock.
- Encoding: jogada = position of the single set bit of amostra (bit 0 maps to 0); width 4, values 9..15 never produced.

Optional Feature:
- Macro: DETECTOR_DEBOUNCE_EN.
- Defined: behaviour as above (ESTAVEL used, DEB_CICLOS honoured).
- Undefined:
  - ESTAVEL and the counter are not built.
  - OCIOSO with habilita=1 and s!=0 captures amostra and goes directly to EMITE.
  - Latency is 3 edges from the first sampling edge.
  - DEB_CICLOS is ignored.
  - All other rules unchanged.

Decomposition:
- Shared package/header jogo_pkg:
  - NUM_BOTOES=9, JOGADA_W=4.
  - State codes OCIOSO=4'd0, ESTAVEL=4'd1, EMITE=4'd2, ESPERA_SOLTAR=4'd3; circuito_jogo reuses the db_estado convention.
- One sub-module: sincronizador_2ff, parameter WIDTH, async active-high reset to 0.
- Keep the one-hot check and index encoding inline.

Test Plan:
- Reset pulse for 1 cycle, then 10 idle cycles -> all outputs 0, db_estado=0.
- habilita=1, botoes=9'b000001000 for 2 cycles -> one jogada_valida pulse, jogada=4'd3, jogada_onehot=9'b000001000, db_estado reaches 3 then returns to 0.
- habilita=1, botoes=9'b000010000 held for 40 cycles -> exactly one pulse, jogada=4'd4; no further pulse until release and a new press.
- habilita=1, botoes=9'b000000011 for 5 cycles -> erro_jogada pulse once, jogada_valida never asserted, jogada keeps its previous value.
- habilita=0, botoes=9'b000000010 pressed, habilita raised while held, then release and press again -> no pulse for the first press, one pulse with jogada=4'd1 for the second.
- Without DETECTOR_DEBOUNCE_EN: a 1-cycle press of bit 8 -> pulse with jogada=4'd8. With the macro defined: a 1-cycle press -> no pulse (DEB_CICLOS=2).
